// File: rtl/ripple_count_capture.sv
// ripple_count_capture: brings an asynchronous ripple counter into the clk domain,
// extends it with a synchronous wrap-count word and offers snapshots over valid/ready.
//
// Optional feature macro: RCC_MATCH_EN (adds match_val / match_pulse).
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   cnt_in       raw ripple counter bits, asynchronous to clk
//   clr          synchronous clear of extension, sticky flags and snapshot FSM
//   snap_req     snapshot request, honoured in IDLE only
//   out_ready    consumer accepts the snapshot
//   out_valid    snapshot valid
//   out_data     snapshot {ext, cnt_q}
//   wrap_pulse   one-cycle pulse per accepted wrap of cnt_in
//   ext_ovf      sticky, extension word rolled over
//   snap_overrun sticky, snap_req seen outside IDLE
//   match_val    (RCC_MATCH_EN) compare value for {ext, cnt_q}
//   match_pulse  (RCC_MATCH_EN) one-cycle pulse when {ext, cnt_q} changes to match_val
module ripple_count_capture #(
    parameter int CNT_W      = 4,
    parameter int EXT_W      = 12,
    parameter int STABLE_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CNT_W-1:0]       cnt_in,
    input  logic                   clr,
    input  logic                   snap_req,
    input  logic                   out_ready,
`ifdef RCC_MATCH_EN
    input  logic [CNT_W+EXT_W-1:0] match_val,
    output logic                   match_pulse,
`endif
    output logic                   out_valid,
    output logic [CNT_W+EXT_W-1:0] out_data,
    output logic                   wrap_pulse,
    output logic                   ext_ovf,
    output logic                   snap_overrun
);
    localparam int RUN_W = $clog2(STABLE_CYC + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYC);

    typedef enum logic [1:0] {IDLE, ARM, VALID} state_t;

    state_t           state;
    logic [CNT_W-1:0] sync1, sync2, hist, cnt_q, cnt_q_n;
    logic [EXT_W-1:0] ext, ext_n;
    logic [RUN_W-1:0] run, run_n;
    logic             eq, stable, accept, wrap;

    // stable also requires the current sample pair to agree, so a fresh change
    // in sync2 cannot ride on a run count saturated by the previous value.
    always_comb begin
        eq      = sync2 == hist;
        run_n   = !eq ? '0 : (run == RUN_MAX ? run : run + RUN_W'(1));
        stable  = eq && run == RUN_MAX;
        accept  = stable && sync2 != cnt_q;
        wrap    = accept && sync2 < cnt_q;
        cnt_q_n = accept ? sync2 : cnt_q;
        ext_n   = clr ? '0 : (wrap ? ext + EXT_W'(1) : ext);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1        <= '0;
            sync2        <= '0;
            hist         <= '0;
            run          <= '0;
            cnt_q        <= '0;
            ext          <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            wrap_pulse   <= 1'b0;
            ext_ovf      <= 1'b0;
            snap_overrun <= 1'b0;
            state        <= IDLE;
`ifdef RCC_MATCH_EN
            match_pulse  <= 1'b0;
`endif
        end else begin
            sync1        <= cnt_in;
            sync2        <= sync1;
            hist         <= sync2;
            run          <= run_n;
            cnt_q        <= cnt_q_n;
            ext          <= ext_n;
            wrap_pulse   <= wrap && !clr;
            ext_ovf      <= !clr && (ext_ovf || (wrap && &ext));
            snap_overrun <= !clr && (snap_overrun || (snap_req && state != IDLE));
`ifdef RCC_MATCH_EN
            match_pulse  <= !clr && {ext_n, cnt_q_n} != {ext, cnt_q} && {ext_n, cnt_q_n} == match_val;
`endif
            if (clr) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (snap_req) state <= ARM;
                    ARM: begin
                        // wait until no acceptance is pending so the snapshot is coherent
                        if (stable && sync2 == cnt_q) begin
                            out_data  <= {ext, cnt_q};
                            out_valid <= 1'b1;
                            state     <= VALID;
                        end
                    end
                    VALID: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ripple_count_capture.sv
// tb_ripple_count_capture: directed self-checking bench for ripple_count_capture.
module tb_ripple_count_capture;
    logic        clk = 1'b0, rst = 1'b1, clr = 1'b0, snap_req = 1'b0, out_ready = 1'b0;
    logic [3:0]  cnt_in = 4'd0;
    logic        out_valid, wrap_pulse, ext_ovf, snap_overrun;
    logic [15:0] out_data;
    int          compared = 0, mismatched = 0, wraps = 0, w0;
    logic        glitch_seen = 1'b0;
`ifdef RCC_MATCH_EN
    logic        match_pulse;
    logic [15:0] match_val = 16'h0;
`endif

    ripple_count_capture dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr), .snap_req(snap_req),
        .out_ready(out_ready),
`ifdef RCC_MATCH_EN
        .match_val(match_val), .match_pulse(match_pulse),
`endif
        .out_valid(out_valid), .out_data(out_data), .wrap_pulse(wrap_pulse),
        .ext_ovf(ext_ovf), .snap_overrun(snap_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wrap_pulse) wraps <= wraps + 1;
        if (dut.cnt_q == 4'd6 || dut.cnt_q == 4'd4) glitch_seen <= 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        cnt_in = v;
        tick(n);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        tick(20);
        check("rst_cnt_q", dut.cnt_q, 0);
        check("rst_ext", dut.ext, 0);
        check("rst_valid", out_valid, 0);
        check("rst_wraps", wraps, 0);
        check("rst_flags", {ext_ovf, snap_overrun}, 0);

        cnt_in = 4'd1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("lat_hold", dut.cnt_q, 0);
        end
        tick(1);
        check("lat_accept", dut.cnt_q, 1);

        hold(4'd7, 8);
        check("glitch_pre", dut.cnt_q, 7);
        hold(4'd6, 1);
        hold(4'd4, 1);
        hold(4'd8, 10);
        check("glitch_final", dut.cnt_q, 8);
        check("glitch_seen", glitch_seen, 0);

        w0 = wraps;
        hold(4'd14, 8);
        hold(4'd15, 8);
        hold(4'd0, 8);
        check("wrap_one", wraps - w0, 1);
        hold(4'd1, 8);
        check("wrap_count", wraps - w0, 1);
        check("wrap_ext_cnt", {dut.ext, dut.cnt_q}, 16'h0011);

        hold(4'd8, 8);
        hold(4'd0, 8);
        hold(4'd8, 8);
        hold(4'd0, 8);
        hold(4'd9, 8);
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        tick(1);
        check("snap_valid", {out_valid, out_data}, 17'h10039);
        cnt_in = 4'd10;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check("snap_hold", {out_valid, out_data}, 17'h10039);
        end
        check("snap_cnt_moved", dut.cnt_q, 10);
        check("no_overrun", snap_overrun, 0);
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        check("overrun_set", snap_overrun, 1);
        check("overrun_ignored", {out_valid, out_data}, 17'h10039);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("hs_done", out_valid, 0);
        tick(2);
        check("hs_idle", out_valid, 0);
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        tick(1);
        check("resnap", {out_valid, out_data}, 17'h1003A);

        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_valid", out_valid, 0);
        check("clr_overrun", snap_overrun, 0);
        check("clr_ext_cnt", {dut.ext, dut.cnt_q}, 16'h000A);

        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        tick(1);
        check("sim_valid", {out_valid, out_data}, 17'h1000A);
        snap_req = 1'b1;
        out_ready = 1'b1;
        tick(1);
        snap_req = 1'b0;
        out_ready = 1'b0;
        check("sim_done", out_valid, 0);
        check("sim_overrun", snap_overrun, 1);
        tick(3);
        check("sim_not_queued", out_valid, 0);

        hold(4'd0, 6);
        for (int i = 0; i < 4094; i++) begin
            hold(4'd8, 6);
            hold(4'd0, 6);
        end
        hold(4'd15, 6);
        check("ovf_pre", {dut.ext, dut.cnt_q}, 16'hFFFF);
        check("ovf_pre_flag", ext_ovf, 0);
        w0 = wraps;
        hold(4'd0, 7);
        check("ovf_ext_cnt", {dut.ext, dut.cnt_q}, 16'h0000);
        check("ovf_flag", ext_ovf, 1);
        check("ovf_wrap", wraps - w0, 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("ovf_clr_flags", {ext_ovf, snap_overrun}, 0);
        check("ovf_clr_cnt", dut.cnt_q, 0);

        hold(4'd8, 6);
        hold(4'd0, 6);
        check("pre_coinc_ext", dut.ext, 1);
        hold(4'd8, 6);
        w0 = wraps;
        cnt_in = 4'd0;
        tick(5);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("coinc_ext_cnt", {dut.ext, dut.cnt_q}, 16'h0000);
        tick(2);
        check("coinc_no_pulse", wraps - w0, 0);

        hold(4'd5, 8);
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        tick(1);
        check("pre_rst_snap", {out_valid, out_data}, 17'h10005);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out", {out_valid, out_data}, 0);
        check("async_rst_cnt", {dut.ext, dut.cnt_q}, 0);
        tick(1);
        rst = 1'b0;
        tick(10);
        check("rst_discard", out_valid, 0);
        check("rst_retrack", dut.cnt_q, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
